// File: rtl/aes_pkg.sv
// aes_pkg: shared types for the AES command front-end.
//   opcode        - AES command opcodes accepted by the issue queue
//   issue_state_t - issue FSM states
//   AES_DATA_W    - width of AES state / key / result words
//   OPCODE_W      - encoded opcode width
package aes_pkg;

  localparam int AES_DATA_W = 128;
  localparam int OPCODE_W   = 3;

  typedef enum logic [2:0] {
    NOOP            = 3'd0,
    AESENC          = 3'd1,
    AESENCLAST      = 3'd2,
    AESKEYGENASSIST = 3'd3,
    AESENCFULL      = 3'd4
  } opcode;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } issue_state_t;

endpackage

// File: rtl/aes_cmd_fifo.sv
// aes_cmd_fifo: small synchronous FIFO holding packed AES commands.
//   clk, rst       - clock, synchronous active-high reset
//   push_i, din_i  - write strobe and entry (ignored when full)
//   pop_i, dout_o  - read strobe and head entry (head valid when !empty_o)
//   full_o,empty_o - flags decoded from the registered occupancy count
// Full is derived from the registered count only, so a pop never frees a
// slot for a push in the same cycle.
module aes_cmd_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_r == CNT_W'(DEPTH));
  assign empty_o   = (count_r == {CNT_W{1'b0}});
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign dout_o    = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; simultaneous push+pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din_i;
    end
  end

endmodule

// File: rtl/aes_issue_q.sv
// aes_issue_q: command front-end for the AES core.
//   clk, rst                       - clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o        - command handshake (ready = FIFO not full)
//   cmd_opcode_i/data_i/key_i/tag_i- command payload
//   start_o                        - one-cycle issue pulse to the core
//   opcode_o, data_o, key_o        - issued operands, stable from issue to completion
//   cipher_ready_i, key_ready_i    - core completion pulses
//   result_i                       - core result, valid with a completion pulse
//   rsp_valid_o/rsp_ready_i        - response handshake
//   rsp_data_o, rsp_tag_o, rsp_err_o - response payload (data 0 on error)
//   done_cnt_o                     - wrapping count of delivered responses
module aes_issue_q
  import aes_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 64,
  parameter int TAG_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  opcode                 cmd_opcode_i,
  input  logic [AES_DATA_W-1:0] cmd_data_i,
  input  logic [AES_DATA_W-1:0] cmd_key_i,
  input  logic [TAG_W-1:0]      cmd_tag_i,
  output logic                  start_o,
  output opcode                 opcode_o,
  output logic [AES_DATA_W-1:0] data_o,
  output logic [AES_DATA_W-1:0] key_o,
  input  logic                  cipher_ready_i,
  input  logic                  key_ready_i,
  input  logic [AES_DATA_W-1:0] result_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [AES_DATA_W-1:0] rsp_data_o,
  output logic [TAG_W-1:0]      rsp_tag_o,
  output logic                  rsp_err_o,
  output logic [15:0]           done_cnt_o
);

  localparam int ENT_W = OPCODE_W + 2 * AES_DATA_W + TAG_W;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  issue_state_t          state_r;
  logic                  start_r;
  opcode                 opcode_r;
  logic [AES_DATA_W-1:0] data_r;
  logic [AES_DATA_W-1:0] key_r;
  logic [TAG_W-1:0]      tag_r;
  logic [TMR_W-1:0]      timer_r;
  logic                  rsp_valid_r;
  logic [AES_DATA_W-1:0] rsp_data_r;
  logic [TAG_W-1:0]      rsp_tag_r;
  logic                  rsp_err_r;
  logic [15:0]           done_cnt_r;

  logic [ENT_W-1:0]      fifo_din_s;
  logic [ENT_W-1:0]      fifo_head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  pop_s;
  opcode                 head_op_s;
  logic [AES_DATA_W-1:0] head_data_s;
  logic [AES_DATA_W-1:0] head_key_s;
  logic [TAG_W-1:0]      head_tag_s;
  logic                  exp_pulse_s;
  logic                  oth_pulse_s;

  assign fifo_din_s  = {cmd_opcode_i, cmd_data_i, cmd_key_i, cmd_tag_i};
  assign head_op_s   = opcode'(fifo_head_s[ENT_W-1 -: OPCODE_W]);
  assign head_data_s = fifo_head_s[TAG_W+2*AES_DATA_W-1 -: AES_DATA_W];
  assign head_key_s  = fifo_head_s[TAG_W+AES_DATA_W-1 -: AES_DATA_W];
  assign head_tag_s  = fifo_head_s[TAG_W-1:0];

  // The head is consumed whenever the FSM idles with work queued, NOOPs included.
  assign pop_s       = (state_r == ST_IDLE) && !fifo_empty_s;
  assign cmd_ready_o = !fifo_full_s;

  aes_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid_i),
    .din_i   (fifo_din_s),
    .pop_i   (pop_s),
    .dout_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Classify completion pulses against the in-flight opcode.
  always_comb begin
    exp_pulse_s = 1'b0;
    oth_pulse_s = 1'b0;
    if (opcode_r == AESKEYGENASSIST) begin
      exp_pulse_s = key_ready_i;
      oth_pulse_s = cipher_ready_i;
    end else begin
      exp_pulse_s = cipher_ready_i;
      oth_pulse_s = key_ready_i;
    end
  end

  // Issue FSM with watchdog, response registers and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      start_r     <= 1'b0;
      opcode_r    <= NOOP;
      data_r      <= {AES_DATA_W{1'b0}};
      key_r       <= {AES_DATA_W{1'b0}};
      tag_r       <= {TAG_W{1'b0}};
      timer_r     <= {TMR_W{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {AES_DATA_W{1'b0}};
      rsp_tag_r   <= {TAG_W{1'b0}};
      rsp_err_r   <= 1'b0;
      done_cnt_r  <= 16'd0;
    end else begin
      start_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Operands only change here, so they stay put through ISSUE and WAIT.
          if (pop_s && (head_op_s != NOOP)) begin
            opcode_r <= head_op_s;
            data_r   <= head_data_s;
            key_r    <= head_key_s;
            tag_r    <= head_tag_s;
            start_r  <= 1'b1;
            state_r  <= ST_ISSUE;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          timer_r <= {TMR_W{1'b0}};
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // Expected pulse wins when both arrive together.
          if (exp_pulse_s) begin
            rsp_data_r  <= result_i;
            rsp_err_r   <= 1'b0;
            rsp_tag_r   <= tag_r;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else if (oth_pulse_s || (timer_r == TMR_LAST)) begin
            rsp_data_r  <= {AES_DATA_W{1'b0}};
            rsp_err_r   <= 1'b1;
            rsp_tag_r   <= tag_r;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else begin
            timer_r     <= timer_r + TMR_W'(1);
            state_r     <= ST_WAIT;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            done_cnt_r  <= done_cnt_r + 16'd1;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_RESP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign start_o     = start_r;
  assign opcode_o    = opcode_r;
  assign data_o      = data_r;
  assign key_o       = key_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_data_o  = rsp_data_r;
  assign rsp_tag_o   = rsp_tag_r;
  assign rsp_err_o   = rsp_err_r;
  assign done_cnt_o  = done_cnt_r;

endmodule
